// File: rtl/dual_issue_queue.sv
// Purpose : in-order dual-issue pairing queue between decode and execute; offers the two
//           oldest entries as a pair when independent, else the oldest alone (oldest in slot 0).
// Latency : an enqueued entry is visible at the outputs the cycle after its write; outputs are
//           combinational from the head registers.
// Backpr. : in_ready drops when fewer than 2 entries are free (same-cycle pop not counted);
//           the offered group holds steady while out_ready is low.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   flush                   synchronous clear; overrides that cycle's enqueue and dequeue
//   in_valid[1:0]           lane valids (lane0 older); 01 = one, 11 = two, 10 ignored
//   in_instr0/in_instr1     lane instructions
//   in_ready                at least two free entries
//   out_valid[1:0]          00 none, 01 slot0 only, 11 pair
//   out_instr0/out_instr1   oldest / second-oldest entry
//   out_ready               downstream takes the whole offered group
//   occupancy               entries currently held
//   split_pulse             accepted group was single-issue because of a hazard
module dual_issue_queue #(
  parameter int INSTR_W   = 16,
  parameter int DEPTH     = 8,
  parameter int REG_W     = 3,
  parameter int RD_LSB    = 8,
  parameter int RS1_LSB   = 5,
  parameter int RS2_LSB   = 2,
  parameter int IMM_BIT   = 11,
  parameter int DUAL_EN   = 1,
  parameter int CHECK_WAR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [1:0]                 in_valid,
  input  logic [INSTR_W-1:0]         in_instr0,
  input  logic [INSTR_W-1:0]         in_instr1,
  output logic                       in_ready,
  output logic [1:0]                 out_valid,
  output logic [INSTR_W-1:0]         out_instr0,
  output logic [INSTR_W-1:0]         out_instr1,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       split_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic DUAL_ON = (DUAL_EN != 0);
  localparam logic WAR_ON  = (CHECK_WAR != 0);

  // Storage and pointers. DEPTH is a power of two, so pointer arithmetic wraps for free.
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [OCC_W-1:0]   occ_q;

  logic [PTR_W-1:0]   rd_ptr_p1;
  logic [PTR_W-1:0]   wr_ptr_p1;
  logic [INSTR_W-1:0] entry_a;
  logic [INSTR_W-1:0] entry_b;

  assign rd_ptr_p1 = rd_ptr + 1'b1;
  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign entry_a   = mem[rd_ptr];
  assign entry_b   = mem[rd_ptr_p1];

  // Register fields of the two head entries.
  logic [REG_W-1:0] a_rd, a_rs1, a_rs2;
  logic [REG_W-1:0] b_rd, b_rs1, b_rs2;
  logic             a_imm, b_imm;

  assign a_rd  = entry_a[RD_LSB  +: REG_W];
  assign a_rs1 = entry_a[RS1_LSB +: REG_W];
  assign a_rs2 = entry_a[RS2_LSB +: REG_W];
  assign a_imm = entry_a[IMM_BIT];
  assign b_rd  = entry_b[RD_LSB  +: REG_W];
  assign b_rs1 = entry_b[RS1_LSB +: REG_W];
  assign b_rs2 = entry_b[RS2_LSB +: REG_W];
  assign b_imm = entry_b[IMM_BIT];

  // Pairing hazard between older A and younger B:
  //   RAW: B reads A's destination (rs2 only counts for register-form B)
  //   WAW: both write the same destination
  //   WAR: B overwrites a source of A (optional; rs2 only for register-form A)
  logic raw_hz, waw_hz, war_hz, hazard;

  assign raw_hz = (b_rs1 == a_rd) | (!b_imm & (b_rs2 == a_rd));
  assign waw_hz = (b_rd == a_rd);
  assign war_hz = WAR_ON & ((b_rd == a_rs1) | (!a_imm & (b_rd == a_rs2)));
  assign hazard = raw_hz | waw_hz | war_hz;

  logic have_one, have_two;
  assign have_one = (occ_q != '0);
  assign have_two = (occ_q >= OCC_W'(2));

  // Offered group.
  always_comb begin
    out_valid = 2'b00;
    if (have_two) begin
      out_valid = (DUAL_ON && !hazard) ? 2'b11 : 2'b01;
    end else if (have_one) begin
      out_valid = 2'b01;
    end
  end

  assign out_instr0  = entry_a;
  assign out_instr1  = entry_b;
  // Only a hazard-induced split counts; a lone entry is not a split.
  assign split_pulse = out_ready & have_two & DUAL_ON & hazard;

  // in_ready looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready  = (occ_q <= OCC_W'(DEPTH - 2));
  assign occupancy = occ_q;

  // Push / pop counts. Lane pattern 10 has no older instruction and is dropped.
  logic [1:0] push_cnt;
  logic [1:0] pop_cnt;

  always_comb begin
    push_cnt = 2'd0;
    if (in_ready) begin
      case (in_valid)
        2'b01:   push_cnt = 2'd1;
        2'b11:   push_cnt = 2'd2;
        default: push_cnt = 2'd0;
      endcase
    end
  end

  always_comb begin
    pop_cnt = 2'd0;
    if (out_ready) begin
      case (out_valid)
        2'b01:   pop_cnt = 2'd1;
        2'b11:   pop_cnt = 2'd2;
        default: pop_cnt = 2'd0;
      endcase
    end
  end

  logic [OCC_W-1:0] occ_next;
  assign occ_next = occ_q + OCC_W'(push_cnt) - OCC_W'(pop_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any same-cycle enqueue or dequeue.
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push_cnt != 2'd0) begin
        mem[wr_ptr] <= in_instr0;
      end
      if (push_cnt == 2'd2) begin
        mem[wr_ptr_p1] <= in_instr1;
      end
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      occ_q  <= occ_next;
    end
  end

endmodule

// File: tb/tb_dual_issue_queue.sv
module tb_dual_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  in_valid;
  logic [15:0] in_instr0, in_instr1;
  logic        out_ready;

  logic        in_ready,   s_in_ready;
  logic [1:0]  out_valid,  s_out_valid;
  logic [15:0] out_instr0, s_out_instr0;
  logic [15:0] out_instr1, s_out_instr1;
  logic [3:0]  occupancy,  s_occupancy;
  logic        split_pulse, s_split_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dual_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_instr0(in_instr0), .in_instr1(in_instr1),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_ready(out_ready), .occupancy(occupancy), .split_pulse(split_pulse)
  );

  // Single-issue variant sharing the same stimulus.
  dual_issue_queue #(.DUAL_EN(0)) dut_single (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_instr0(in_instr0), .in_instr1(in_instr1),
    .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_instr0(s_out_instr0), .out_instr1(s_out_instr1),
    .out_ready(out_ready), .occupancy(s_occupancy), .split_pulse(s_split_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    n_checks++; if (out_instr0 !== 16'h0) begin n_fail++; $display("FAIL reset_out_instr0: got %h want 0000", out_instr0); end
    n_checks++; if (out_instr1 !== 16'h0) begin n_fail++; $display("FAIL reset_out_instr1: got %h want 0000", out_instr1); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_checks++; if (split_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_split: got %b want 0", split_pulse); end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_independent();
    in_valid = 2'b11; in_instr0 = 16'h014C; in_instr1 = 16'h04B8; out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL indep_pre_valid: got %b want 00", out_valid); end
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL indep_valid: got %b want 11", out_valid); end
    n_checks++; if (out_instr0 !== 16'h014C) begin n_fail++; $display("FAIL indep_instr0: got %h want 014c", out_instr0); end
    n_checks++; if (out_instr1 !== 16'h04B8) begin n_fail++; $display("FAIL indep_instr1: got %h want 04b8", out_instr1); end
    n_checks++; if (split_pulse !== 1'b0) begin n_fail++; $display("FAIL indep_split: got %b want 0", split_pulse); end
    tick();
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL indep_drained_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_raw();
    in_valid = 2'b11; in_instr0 = 16'h014C; in_instr1 = 16'h0438; out_ready = 1'b1;
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL raw_valid0: got %b want 01", out_valid); end
    n_checks++; if (out_instr0 !== 16'h014C) begin n_fail++; $display("FAIL raw_instr0_first: got %h want 014c", out_instr0); end
    n_checks++; if (split_pulse !== 1'b1) begin n_fail++; $display("FAIL raw_split: got %b want 1", split_pulse); end
    tick();
    n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL raw_valid1: got %b want 01", out_valid); end
    n_checks++; if (out_instr0 !== 16'h0438) begin n_fail++; $display("FAIL raw_instr0_second: got %h want 0438", out_instr0); end
    n_checks++; if (split_pulse !== 1'b0) begin n_fail++; $display("FAIL raw_split_lone: got %b want 0", split_pulse); end
    tick();
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL raw_drained_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_immediate();
    // Clear both instances so they start from the same empty state.
    flush = 1'b1; in_valid = 2'b00;
    tick();
    flush = 1'b0;
    in_valid = 2'b11; in_instr0 = 16'h014C; in_instr1 = 16'h0CA4; out_ready = 1'b1;
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL imm_valid: got %b want 11", out_valid); end
    n_checks++; if (out_instr1 !== 16'h0CA4) begin n_fail++; $display("FAIL imm_instr1: got %h want 0ca4", out_instr1); end
    n_checks++; if (split_pulse !== 1'b0) begin n_fail++; $display("FAIL imm_split: got %b want 0", split_pulse); end
    n_checks++; if (s_out_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid0: got %b want 01", s_out_valid); end
    n_checks++; if (s_out_instr0 !== 16'h014C) begin n_fail++; $display("FAIL single_instr0_first: got %h want 014c", s_out_instr0); end
    n_checks++; if (s_split_pulse !== 1'b0) begin n_fail++; $display("FAIL single_split0: got %b want 0", s_split_pulse); end
    tick();
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL imm_drained_occ: got %0d want 0", occupancy); end
    n_checks++; if (s_out_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid1: got %b want 01", s_out_valid); end
    n_checks++; if (s_out_instr0 !== 16'h0CA4) begin n_fail++; $display("FAIL single_instr0_second: got %h want 0ca4", s_out_instr0); end
    n_checks++; if (s_split_pulse !== 1'b0) begin n_fail++; $display("FAIL single_split1: got %b want 0", s_split_pulse); end
    tick();
    n_checks++; if (s_occupancy !== 4'd0) begin n_fail++; $display("FAIL single_drained_occ: got %0d want 0", s_occupancy); end
  endtask

  task automatic test_illegal_lane();
    in_valid = 2'b10; in_instr0 = 16'h1111; in_instr1 = 16'h2222; out_ready = 1'b0;
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL illegal_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL illegal_valid: got %b want 00", out_valid); end
  endtask

  task automatic test_full();
    logic [3:0] ii;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ii = 4'(i);
      in_valid = 2'b11;
      in_instr0 = {ii, 12'h14C};
      in_instr1 = {ii, 12'h4B8};
      #1;
      if (i == 3) begin
        n_checks++; if (occupancy !== 4'd6) begin n_fail++; $display("FAIL full_occ6: got %0d want 6", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_at6: got %b want 1", in_ready); end
      end
      tick();
    end
    in_valid = 2'b11; in_instr0 = 16'hF14C; in_instr1 = 16'hF4B8;
    #1;
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occ8: got %0d want 8", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_at8: got %b want 0", in_ready); end
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_fifth_push: got %0d want 8", occupancy); end
    n_checks++; if (out_instr0 !== 16'h014C) begin n_fail++; $display("FAIL full_stable_head: got %h want 014c", out_instr0); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ii = 4'(i);
      #1;
      n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL drain%0d_valid: got %b want 11", i, out_valid); end
      n_checks++; if (out_instr0 !== {ii, 12'h14C}) begin n_fail++; $display("FAIL drain%0d_instr0: got %h want %h", i, out_instr0, {ii, 12'h14C}); end
      n_checks++; if (out_instr1 !== {ii, 12'h4B8}) begin n_fail++; $display("FAIL drain%0d_instr1: got %h want %h", i, out_instr1, {ii, 12'h4B8}); end
      tick();
    end
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL drain_valid: got %b want 00", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  kk;
    logic [15:0] a, b, pa, pb;
    pa = '0; pb = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      kk = 6'(k);
      a = {kk[3:0], 12'h14C} | {14'h0, kk[5:4]};
      b = {kk[3:0], 12'h4B8} | {14'h0, kk[5:4]};
      in_valid = 2'b11; in_instr0 = a; in_instr1 = b;
      #1;
      if (k > 0) begin
        n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL b2b%0d_valid: got %b want 11", k, out_valid); end
        n_checks++; if (out_instr0 !== pa) begin n_fail++; $display("FAIL b2b%0d_instr0: got %h want %h", k, out_instr0, pa); end
        n_checks++; if (out_instr1 !== pb) begin n_fail++; $display("FAIL b2b%0d_instr1: got %h want %h", k, out_instr1, pb); end
        n_checks++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL b2b%0d_occ: got %0d want 2", k, occupancy); end
      end
      pa = a; pb = b;
      tick();
    end
    in_valid = 2'b00;
    #1;
    n_checks++; if (out_instr0 !== pa) begin n_fail++; $display("FAIL b2b_last_instr0: got %h want %h", out_instr0, pa); end
    n_checks++; if (out_instr1 !== pb) begin n_fail++; $display("FAIL b2b_last_instr1: got %h want %h", out_instr1, pb); end
    tick();
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL b2b_drained_occ: got %0d want 0", occupancy); end
  endtask

  // Leaves the queue holding 5 entries with out_ready low.
  task automatic fill_five();
    out_ready = 1'b0;
    in_valid = 2'b11; in_instr0 = 16'h514C; in_instr1 = 16'h54B8; tick();
    in_valid = 2'b11; in_instr0 = 16'h614C; in_instr1 = 16'h64B8; tick();
    in_valid = 2'b01; in_instr0 = 16'h714C; tick();
    in_valid = 2'b00;
  endtask

  task automatic test_flush();
    fill_five();
    #1;
    n_checks++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 5", occupancy); end
    flush = 1'b1; in_valid = 2'b11; in_instr0 = 16'hDEAD; in_instr1 = 16'hBEEF; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 2'b00;
    #1;
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b want 00", out_valid); end
    in_valid = 2'b01; in_instr0 = 16'h0123;
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL flush_repush_occ: got %0d want 1", occupancy); end
    n_checks++; if (out_valid !== 2'b01) begin n_fail++; $display("FAIL flush_repush_valid: got %b want 01", out_valid); end
    n_checks++; if (out_instr0 !== 16'h0123) begin n_fail++; $display("FAIL flush_repush_instr0: got %h want 0123", out_instr0); end
    tick();
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_final_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_async_reset();
    fill_five();
    #2;
    rst_n = 1'b0; in_valid = 2'b11; in_instr0 = 16'hDEAD; in_instr1 = 16'hBEEF;
    #1;
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL arst_valid: got %b want 00", out_valid); end
    n_checks++; if (out_instr0 !== 16'h0) begin n_fail++; $display("FAIL arst_instr0: got %h want 0000", out_instr0); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", in_ready); end
    tick();
    #2;
    rst_n = 1'b1; in_valid = 2'b00;
    #1;
    n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL arst_held_occ: got %0d want 0", occupancy); end
    tick();
    in_valid = 2'b01; in_instr0 = 16'h0456; out_ready = 1'b0;
    tick();
    in_valid = 2'b00;
    #1;
    n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL arst_repush_occ: got %0d want 1", occupancy); end
    n_checks++; if (out_instr0 !== 16'h0456) begin n_fail++; $display("FAIL arst_repush_instr0: got %h want 0456", out_instr0); end
    n_checks++; if (out_instr1 !== 16'h0) begin n_fail++; $display("FAIL arst_slot1_cleared: got %h want 0000", out_instr1); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 2'b00;
    in_instr0 = '0; in_instr1 = '0; out_ready = 1'b0;
    test_reset();
    test_independent();
    test_raw();
    test_immediate();
    test_illegal_lane();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
